// File: rtl/mixer_duc_cmul_pipe_if.sv
// Stream and status bundle for the DUC mixer complex multiplier.
// The master side feeds samples and drains results; the slave side is the multiplier.
interface mixer_duc_cmul_pipe_if #(
    parameter int DIN_W  = 16,
    parameter int COEF_W = 8,
    parameter int DOUT_W = 16,
    parameter int TAG_W  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DIN_W-1:0]  din_i;
    logic signed [DIN_W-1:0]  din_q;
    logic signed [COEF_W-1:0] cos_in;
    logic signed [COEF_W-1:0] sin_in;
    logic                     mode_dn;
    logic [TAG_W-1:0]         tag_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DOUT_W-1:0] dout_i;
    logic signed [DOUT_W-1:0] dout_q;
    logic [TAG_W-1:0]         tag_out;
    logic                     sat_pulse;
    logic [15:0]              sat_cnt;
    logic                     sat_clr;

    modport master (
        output in_valid, din_i, din_q, cos_in, sin_in, mode_dn, tag_in, out_ready, sat_clr,
        input  in_ready, out_valid, dout_i, dout_q, tag_out, sat_pulse, sat_cnt
    );

    modport slave (
        input  in_valid, din_i, din_q, cos_in, sin_in, mode_dn, tag_in, out_ready, sat_clr,
        output in_ready, out_valid, dout_i, dout_q, tag_out, sat_pulse, sat_cnt
    );
endinterface

// File: rtl/mixer_duc_cmul_pipe.sv
// Pipelined signed complex multiply of an I/Q sample by an NCO phasor, with
// round-half-up, arithmetic shift and saturation to the output width.
module mixer_duc_cmul_pipe #(
    parameter int DIN_W     = 16,
    parameter int COEF_W    = 8,
    parameter int DOUT_W    = 16,
    parameter int SHIFT     = 7,
    parameter int NUM_STAGE = 3,
    parameter int TAG_W     = 4
) (
    input logic                  ap_clk,
    input logic                  ap_rst_n,
    mixer_duc_cmul_pipe_if.slave bus
);
    localparam int PW  = DIN_W + COEF_W;
    localparam int W   = PW + 1;
    localparam int MID = NUM_STAGE - 2;

    localparam logic [W:0]        ONE  = {{W{1'b0}}, 1'b1};
    localparam logic signed [W:0] RND  = $signed(ONE << (SHIFT - 1));
    localparam logic signed [W:0] MAXV = {{(W - DOUT_W + 2){1'b0}}, {(DOUT_W - 1){1'b1}}};
    localparam logic signed [W:0] MINV = {{(W - DOUT_W + 2){1'b1}}, {(DOUT_W - 1){1'b0}}};

    // Result MSB flags a clip; low DOUT_W bits are the rounded, saturated value.
    function automatic logic [DOUT_W:0] sat_round(input logic signed [W-1:0] p);
        logic signed [W:0] r;
        logic [DOUT_W:0]   res;
        r = ((W + 1)'(p) + RND) >>> SHIFT;
        if (r > MAXV) begin
            res = {1'b1, MAXV[DOUT_W-1:0]};
        end else if (r < MINV) begin
            res = {1'b1, MINV[DOUT_W-1:0]};
        end else begin
            res = {1'b0, r[DOUT_W-1:0]};
        end
        return res;
    endfunction

    logic                     ce_s;
    logic                     v1_r, m1_r;
    logic signed [DIN_W-1:0]  i1_r, q1_r;
    logic signed [COEF_W-1:0] c1_r, s1_r;
    logic [TAG_W-1:0]         t1_r;
    logic signed [PW-1:0]     ic_s, qs_s, is_s, qc_s;
    logic signed [PW-1:0]     ic_l_s, qs_l_s, is_l_s, qc_l_s;
    logic                     v_l_s, m_l_s;
    logic [TAG_W-1:0]         t_l_s;
    logic signed [W-1:0]      p_i_s, p_q_s;
    logic [DOUT_W:0]          r_i_s, r_q_s;
    logic                     out_valid_r, sat_pulse_r;
    logic signed [DOUT_W-1:0] dout_i_r, dout_q_r;
    logic [TAG_W-1:0]         tag_out_r;
    logic [15:0]              sat_cnt_r;

    assign ce_s = bus.out_ready | ~out_valid_r;

    // Stage 1: capture sample, phasor, direction and tag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v1_r <= 1'b0;
            m1_r <= 1'b0;
            i1_r <= '0;
            q1_r <= '0;
            c1_r <= '0;
            s1_r <= '0;
            t1_r <= '0;
        end else if (ce_s) begin
            v1_r <= bus.in_valid;
            m1_r <= bus.mode_dn;
            i1_r <= bus.din_i;
            q1_r <= bus.din_q;
            c1_r <= bus.cos_in;
            s1_r <= bus.sin_in;
            t1_r <= bus.tag_in;
        end
    end

    assign ic_s = PW'(i1_r) * PW'(c1_r);
    assign qs_s = PW'(q1_r) * PW'(s1_r);
    assign is_s = PW'(i1_r) * PW'(s1_r);
    assign qc_s = PW'(q1_r) * PW'(c1_r);

    generate
        if (MID > 0) begin : g_mid
            logic signed [PW-1:0] ic_r [MID];
            logic signed [PW-1:0] qs_r [MID];
            logic signed [PW-1:0] is_r [MID];
            logic signed [PW-1:0] qc_r [MID];
            logic                 v_r  [MID];
            logic                 m_r  [MID];
            logic [TAG_W-1:0]     t_r  [MID];

            // Product delay line; bubbles advance with the data.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int k = 0; k < MID; k++) begin
                        ic_r[k] <= '0;
                        qs_r[k] <= '0;
                        is_r[k] <= '0;
                        qc_r[k] <= '0;
                        v_r[k]  <= 1'b0;
                        m_r[k]  <= 1'b0;
                        t_r[k]  <= '0;
                    end
                end else if (ce_s) begin
                    ic_r[0] <= ic_s;
                    qs_r[0] <= qs_s;
                    is_r[0] <= is_s;
                    qc_r[0] <= qc_s;
                    v_r[0]  <= v1_r;
                    m_r[0]  <= m1_r;
                    t_r[0]  <= t1_r;
                    for (int k = 1; k < MID; k++) begin
                        ic_r[k] <= ic_r[k-1];
                        qs_r[k] <= qs_r[k-1];
                        is_r[k] <= is_r[k-1];
                        qc_r[k] <= qc_r[k-1];
                        v_r[k]  <= v_r[k-1];
                        m_r[k]  <= m_r[k-1];
                        t_r[k]  <= t_r[k-1];
                    end
                end
            end

            assign ic_l_s = ic_r[MID-1];
            assign qs_l_s = qs_r[MID-1];
            assign is_l_s = is_r[MID-1];
            assign qc_l_s = qc_r[MID-1];
            assign v_l_s  = v_r[MID-1];
            assign m_l_s  = m_r[MID-1];
            assign t_l_s  = t_r[MID-1];
        end else begin : g_direct
            assign ic_l_s = ic_s;
            assign qs_l_s = qs_s;
            assign is_l_s = is_s;
            assign qc_l_s = qc_s;
            assign v_l_s  = v1_r;
            assign m_l_s  = m1_r;
            assign t_l_s  = t1_r;
        end
    endgenerate

    // Combine products with the conversion-direction sign, then round and clip.
    always_comb begin
        p_i_s = '0;
        p_q_s = '0;
        if (m_l_s) begin
            p_i_s = W'(ic_l_s) + W'(qs_l_s);
            p_q_s = W'(qc_l_s) - W'(is_l_s);
        end else begin
            p_i_s = W'(ic_l_s) - W'(qs_l_s);
            p_q_s = W'(is_l_s) + W'(qc_l_s);
        end
        r_i_s = sat_round(p_i_s);
        r_q_s = sat_round(p_q_s);
    end

    // Output stage: holds steady while downstream stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_r <= 1'b0;
            sat_pulse_r <= 1'b0;
            dout_i_r    <= '0;
            dout_q_r    <= '0;
            tag_out_r   <= '0;
        end else if (ce_s) begin
            out_valid_r <= v_l_s;
            sat_pulse_r <= v_l_s & (r_i_s[DOUT_W] | r_q_s[DOUT_W]);
            dout_i_r    <= r_i_s[DOUT_W-1:0];
            dout_q_r    <= r_q_s[DOUT_W-1:0];
            tag_out_r   <= t_l_s;
        end
    end

    // Sticky-at-max count of clipped beats actually handed downstream.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_cnt_r <= 16'd0;
        end else if (bus.sat_clr) begin
            sat_cnt_r <= 16'd0;
        end else if (out_valid_r && bus.out_ready && sat_pulse_r && (sat_cnt_r != 16'hFFFF)) begin
            sat_cnt_r <= sat_cnt_r + 16'd1;
        end
    end

    assign bus.in_ready  = ce_s;
    assign bus.out_valid = out_valid_r;
    assign bus.sat_pulse = sat_pulse_r;
    assign bus.dout_i    = dout_i_r;
    assign bus.dout_q    = dout_q_r;
    assign bus.tag_out   = tag_out_r;
    assign bus.sat_cnt   = sat_cnt_r;
endmodule

// File: tb/tb_mixer_duc_cmul_pipe.sv
// Bench for mixer_duc_cmul_pipe: three instances (3, 2 and 6 stages) checked
// against an integer reference model through per-instance scoreboards.
module tb_mixer_duc_cmul_pipe;
    localparam int DIN_W = 16, COEF_W = 8, DOUT_W = 16, SHIFT = 7, TAG_W = 4;

    typedef struct {
        logic signed [DOUT_W-1:0] ei;
        logic signed [DOUT_W-1:0] eq;
        logic [TAG_W-1:0]         et;
        logic                     es;
        int                       cy;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic                     d_valid = 1'b0, d_m = 1'b0, d_ordy = 1'b1, d_clr = 1'b0;
    logic                     sweep = 1'b0, lat3 = 1'b1;
    logic signed [DIN_W-1:0]  d_i = '0, d_q = '0;
    logic signed [COEF_W-1:0] d_c = '0, d_s = '0;
    logic [TAG_W-1:0]         d_t = '0;

    logic                     ov [3];
    logic                     ir [3];
    logic                     sp [3];
    logic signed [DOUT_W-1:0] doi [3];
    logic signed [DOUT_W-1:0] doq [3];
    logic [TAG_W-1:0]         tgo [3];
    logic [15:0]              sc [3];
    int                       pushed [3];
    int                       popped [3];

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer complex product, floor((P + 2^(S-1)) / 2^S), clip.
    function automatic exp_t model(input logic signed [DIN_W-1:0] i, input logic signed [DIN_W-1:0] q,
                                   input logic signed [COEF_W-1:0] c, input logic signed [COEF_W-1:0] s,
                                   input logic m, input logic [TAG_W-1:0] t, input int cy);
        longint pv [2];
        longint d, num, r, hi, lo;
        exp_t e;
        d  = longint'(1) << SHIFT;
        hi = (longint'(1) << (DOUT_W - 1)) - 1;
        lo = -(longint'(1) << (DOUT_W - 1));
        if (m) begin
            pv[0] = longint'(i) * longint'(c) + longint'(q) * longint'(s);
            pv[1] = longint'(q) * longint'(c) - longint'(i) * longint'(s);
        end else begin
            pv[0] = longint'(i) * longint'(c) - longint'(q) * longint'(s);
            pv[1] = longint'(i) * longint'(s) + longint'(q) * longint'(c);
        end
        e.es = 1'b0;
        for (int k = 0; k < 2; k++) begin
            num = pv[k] + d / 2;
            r = num / d;
            if ((num % d) != 0 && num < 0) r = r - 1;
            if (r > hi) begin r = hi; e.es = 1'b1; end
            if (r < lo) begin r = lo; e.es = 1'b1; end
            if (k == 0) e.ei = DOUT_W'(r);
            else        e.eq = DOUT_W'(r);
        end
        e.et = t;
        e.cy = cy;
        return e;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int NSK = (k == 0) ? 3 : ((k == 1) ? 2 : 6);
        mixer_duc_cmul_pipe_if #(.DIN_W(DIN_W), .COEF_W(COEF_W), .DOUT_W(DOUT_W), .TAG_W(TAG_W)) bus ();
        mixer_duc_cmul_pipe #(.DIN_W(DIN_W), .COEF_W(COEF_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT),
                              .NUM_STAGE(NSK), .TAG_W(TAG_W))
            dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));

        assign bus.in_valid  = (k == 0) ? d_valid : (d_valid & sweep);
        assign bus.out_ready = (k == 0) ? d_ordy : 1'b1;
        assign bus.sat_clr   = (k == 0) ? d_clr : 1'b0;
        assign bus.din_i   = d_i;
        assign bus.din_q   = d_q;
        assign bus.cos_in  = d_c;
        assign bus.sin_in  = d_s;
        assign bus.mode_dn = d_m;
        assign bus.tag_in  = d_t;
        assign ov[k]  = bus.out_valid;
        assign ir[k]  = bus.in_ready;
        assign sp[k]  = bus.sat_pulse;
        assign doi[k] = bus.dout_i;
        assign doq[k] = bus.dout_q;
        assign tgo[k] = bus.tag_out;
        assign sc[k]  = bus.sat_cnt;

        exp_t sbq [$];
        logic hold_r = 1'b0;
        logic signed [DOUT_W-1:0] hi_r, hq_r;
        logic [TAG_W-1:0] ht_r;
        logic lat_on;
        assign lat_on = (k == 0) ? lat3 : 1'b1;

        always @(negedge ap_clk) begin
            if (!ap_rst_n) begin
                sbq.delete();
                hold_r <= 1'b0;
                pushed[k] <= 0;
                popped[k] <= 0;
            end else begin
                if (hold_r) begin
                    check_eq($sformatf("u%0d_hold_i", k), bus.dout_i, hi_r);
                    check_eq($sformatf("u%0d_hold_q", k), bus.dout_q, hq_r);
                    check_eq($sformatf("u%0d_hold_tag", k), bus.tag_out, ht_r);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        check_eq($sformatf("u%0d_unexpected_out", k), bus.out_valid, 0);
                    end else begin
                        check_eq($sformatf("u%0d_dout_i", k), bus.dout_i, sbq[0].ei);
                        check_eq($sformatf("u%0d_dout_q", k), bus.dout_q, sbq[0].eq);
                        check_eq($sformatf("u%0d_tag", k), bus.tag_out, sbq[0].et);
                        check_eq($sformatf("u%0d_sat_pulse", k), bus.sat_pulse, sbq[0].es);
                        if (lat_on) check_eq($sformatf("u%0d_latency", k), cyc - sbq[0].cy, NSK);
                        void'(sbq.pop_front());
                        popped[k] <= popped[k] + 1;
                    end
                end
                if (bus.out_valid && !bus.out_ready) begin
                    check_eq($sformatf("u%0d_in_ready_stall", k), bus.in_ready, 0);
                    hold_r <= 1'b1;
                    hi_r <= bus.dout_i;
                    hq_r <= bus.dout_q;
                    ht_r <= bus.tag_out;
                end else begin
                    hold_r <= 1'b0;
                end
                if (bus.in_valid && bus.in_ready) begin
                    sbq.push_back(model(bus.din_i, bus.din_q, bus.cos_in, bus.sin_in,
                                        bus.mode_dn, bus.tag_in, cyc));
                    pushed[k] <= pushed[k] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_in(input int i, input int q, input int c, input int s, input logic m, input int t);
        d_valid = 1'b1;
        d_i = DIN_W'(i);
        d_q = DIN_W'(q);
        d_c = COEF_W'(c);
        d_s = COEF_W'(s);
        d_m = m;
        d_t = TAG_W'(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, base, n;
        logic acc;
        logic [3:0] pat;
        pat = 4'b1001;

        #1;
        check_eq("rst_out_valid", ov[0], 0);
        check_eq("rst_dout_i", doi[0], 0);
        check_eq("rst_sat_cnt", sc[0], 0);
        check_eq("rst_in_ready", ir[0], 1);
        repeat (3) tick();
        ap_rst_n = 1'b1;
        tick();

        // Basic up-convert
        set_in(1000, 0, 127, 0, 1'b0, 5);
        tick();
        d_valid = 1'b0;
        repeat (2) tick();
        check_eq("basic_valid", ov[0], 1);
        check_eq("basic_i", doi[0], 992);
        check_eq("basic_q", doq[0], 0);
        check_eq("basic_tag", tgo[0], 5);
        check_eq("basic_sat", sp[0], 0);
        repeat (2) tick();

        // Direction sign, back-to-back samples
        set_in(1000, 500, 0, 64, 1'b0, 1);
        tick();
        set_in(1000, 500, 0, 64, 1'b1, 2);
        tick();
        d_valid = 1'b0;
        tick();
        check_eq("up_i", doi[0], -250);
        check_eq("up_q", doq[0], 500);
        tick();
        check_eq("dn_valid", ov[0], 1);
        check_eq("dn_i", doi[0], 250);
        check_eq("dn_q", doq[0], -500);
        check_eq("dn_tag", tgo[0], 2);
        repeat (2) tick();

        // Saturation and counter
        set_in(-32768, -32768, -128, 127, 1'b0, 9);
        tick();
        d_valid = 1'b0;
        repeat (2) tick();
        check_eq("sat_i", doi[0], 32767);
        check_eq("sat_q", doq[0], 256);
        check_eq("sat_pulse", sp[0], 1);
        check_eq("sat_cnt_pre", sc[0], 0);
        tick();
        check_eq("sat_cnt_one", sc[0], 1);
        check_eq("sat_pulse_idle", sp[0], 0);
        set_in(-32768, -32768, -128, 127, 1'b0, 9);
        tick();
        d_valid = 1'b0;
        repeat (2) tick();
        check_eq("sat_pulse2", sp[0], 1);
        d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        check_eq("sat_clr_prio", sc[0], 0);
        repeat (2) tick();

        // Reset with two samples in flight
        set_in(3000, 100, 50, 20, 1'b0, 3);
        tick();
        set_in(4000, 200, 60, 30, 1'b1, 4);
        tick();
        d_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", ov[0], 0);
        check_eq("mid_rst_i", doi[0], 0);
        check_eq("mid_rst_q", doq[0], 0);
        check_eq("mid_rst_tag", tgo[0], 0);
        check_eq("mid_rst_ready", ir[0], 1);
        repeat (2) tick();
        ap_rst_n = 1'b1;
        check_eq("post_rst_ready", ir[0], 1);
        for (int t = 0; t < 8; t++) begin
            tick();
            check_eq("post_rst_no_stale", ov[0], 0);
        end

        // Backpressure with out_ready pattern 1,0,0,1
        lat3 = 1'b0;
        base = popped[0];
        idx = 0;
        n = 0;
        while (idx < 8 && n < 200) begin
            d_ordy = pat[n % 4];
            set_in((idx + 1) * 128, 0, 1, 0, 1'b0, idx + 1);
            #1;
            acc = ir[0];
            tick();
            if (acc) idx++;
            n++;
        end
        check_eq("bp_accepted", idx, 8);
        d_valid = 1'b0;
        d_ordy = 1'b1;
        repeat (10) tick();
        check_eq("bp_outputs", popped[0] - base, 8);
        check_eq("bp_drained", popped[0], pushed[0]);
        lat3 = 1'b1;

        // Random sweep into all three depths with out_ready held high
        sweep = 1'b1;
        base = popped[1];
        for (int s = 0; s < 64; s++) begin
            set_in(($urandom_range(0, 7) == 0) ? -32768 : int'($urandom()),
                   ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom()),
                   ($urandom_range(0, 5) == 0) ? -128 : int'($urandom()),
                   int'($urandom()), 1'($urandom()), int'($urandom()));
            tick();
        end
        d_valid = 1'b0;
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("sweep_drained_u%0d", k), popped[k], pushed[k]);
        end
        check_eq("sweep_count_u2", popped[1] - base, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mixer_duc_cmul_pipe.md
Name: mixer_duc_cmul_pipe

Overview:
Parametrised, pipelined signed complex multiplier for the DUC mixer path. It multiplies a complex baseband sample (I/Q) by an NCO phasor (cos/sin), with selectable up/down-conversion sign. The result is rounded, shifted and saturated to the output width. It replaces the scalar 16x8 combinational multiplier and adds a valid/ready stream interface, a configurable pipeline depth, a passthrough tag and a saturation counter.

Parameters:
DIN_W, 16, signed width of din_i/din_q
COEF_W, 8, signed width of cos_in/sin_in
DOUT_W, 16, signed width of dout_i/dout_q
SHIFT, 7, arithmetic right shift applied after rounding (legal range 1..DIN_W+COEF_W-1)
NUM_STAGE, 3, pipeline latency in enabled cycles (legal range 2..6)
TAG_W, 4, width of the sideband tag (channel id) carried alongside the data

Ports:
ap_clk  in  1  clock; all state updates on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
din_i  in  DIN_W  sample I, signed
din_q  in  DIN_W  sample Q, signed
cos_in  in  COEF_W  NCO cosine, signed
sin_in  in  COEF_W  NCO sine, signed
mode_dn  in  1  0 = up-convert (x*e^{+jw}), 1 = down-convert (x*e^{-jw}); sampled with the data
tag_in  in  TAG_W  sideband tag, sampled with the data
out_valid  out  1  output valid
out_ready  in  1  downstream accepts the output
dout_i  out  DOUT_W  result I, signed
dout_q  out  DOUT_W  result Q, signed
tag_out  out  TAG_W  tag that travelled with the result
sat_pulse  out  1  high together with out_valid when either output component saturated
sat_cnt  out  16  count of saturated output beats
sat_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset (ap_rst_n low, asynchronous): all stage-valid bits 0, out_valid 0, dout_i/dout_q/tag_out 0, sat_pulse 0, sat_cnt 0. Reset mid-stream discards all in-flight samples. in_ready is 1 while out_valid is 0, so it reads 1 during and after reset.
- Pipeline enable: ce = out_ready OR NOT out_valid. in_ready = ce. A sample is accepted when in_valid AND in_ready.
- When ce=1, every stage advances, bubbles included; the valid bit shifts in with in_valid. When ce=0, the whole pipeline holds and the outputs remain stable. Bubbles are not compressed.
- Latency: an accepted sample appears at the outputs after exactly NUM_STAGE enabled cycles. With out_ready held at 1, throughput is one sample per cycle.
- Stage 1 registers the inputs, mode_dn and tag. The four products (DIN_W+COEF_W bits each) are registered in the middle stages. The final stage registers the rounded and saturated result.
- Arithmetic uses a full-precision sum width of W = DIN_W+COEF_W+1.
  - Up-convert: P_i = i*c - q*s; P_q = i*s + q*c.
  - Down-convert: P_i = i*c + q*s; P_q = q*c - i*s.
- Rounding: R = (P + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift), computed in W+1 bits so it cannot overflow.
- Saturation: if R > 2^(DOUT_W-1)-1, output 2^(DOUT_W-1)-1. If R < -2^(DOUT_W-1), output -2^(DOUT_W-1). Otherwise output R truncated to DOUT_W.
- sat_pulse is 1 in the output beat where either component clipped. It is 0 whenever out_valid is 0.
- sat_cnt increments once per output beat that is transferred (out_valid AND out_ready) with sat_pulse=1. It saturates at 0xFFFF, with no wrap.
- sat_clr forces sat_cnt to 0 on the next edge and takes priority over a simultaneous increment.
- mode_dn and tag are per-sample. Changing them between consecutive samples affects only the samples they were sampled with.

Test Plan:
- Reset/idle: assert ap_rst_n=0 mid-stream with 2 samples in flight -> out_valid=0 and outputs 0 immediately. After release, in_ready=1 and no stale samples ever emerge.
- Basic up-convert, SHIFT=7, NUM_STAGE=3: i=1000, q=0, c=127, s=0, tag=5 -> exactly 3 cycles later dout=(992,0), tag_out=5, sat_pulse=0.
- Mode sign: i=1000, q=500, c=0, s=64, SHIFT=7. mode_dn=0 -> (-250, 500). The next sample with mode_dn=1 -> (250, -500), emitted in the following cycle.
- Saturation: i=q=-32768, c=-128, s=127, mode_dn=0, SHIFT=7 -> dout=(32767, 256), sat_pulse=1, and sat_cnt increments to 1 when the beat transfers. Repeat with sat_clr=1 on the transfer cycle -> sat_cnt reads 0.
- Backpressure: stream 8 samples with values 1..8 (i=k*128, c=1, s=0) while toggling out_ready in the pattern 1,0,0,1,… -> outputs arrive in order as k with none lost or duplicated. Outputs stay stable while out_ready=0, and in_ready is low whenever out_valid=1 and out_ready=0.
- Throughput/latency sweep: for NUM_STAGE in {2,6}, stream 64 random samples with out_ready=1 -> one output per cycle, latency exactly NUM_STAGE, and results bit-exact against the rounding/saturation model above.
